// File: rtl/npn4_tt_sweeper.sv
// Exhaustive 4-input stimulus/capture stage: drives minterms 0..15 into a netlist under test,
// samples y0 after a programmable settle time and hands the truth table out on valid/ready.
module npn4_tt_sweeper #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    output logic        x0,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    input  logic        y0,
    output logic        busy,
    output logic [15:0] tt,
    output logic        mismatch,
    output logic        tt_valid,
    input  logic        tt_ready,
    output logic [7:0]  sweep_cnt
);

    typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

    localparam logic [3:0] SettleInit = 4'(SETTLE);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] tt_q, tt_d;
    logic        mis_q, mis_d;
    logic [7:0]  sweep_q, sweep_d;

    logic        accept;
    logic        sample;
    logic        last;
    logic        handshake;
    logic [15:0] shift_in;

    assign accept    = (state_q == StIdle) && start;
    assign sample    = (state_q == StDrive) && (cnt_q == 4'd0);
    assign last      = sample && (idx_q == 4'hf);
    assign handshake = (state_q == StHold) && tt_ready;
    // Minterm 0 enters at the top and ends up in bit 0 after 16 shifts.
    assign shift_in  = {y0, shift_q[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start)    state_d = StDrive;
            StDrive: if (last)     state_d = StHold;
            StHold:  if (tt_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        {x3, x2, x1, x0} = 4'b0000;
        busy             = 1'b0;
        tt_valid         = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StDrive: begin
                {x3, x2, x1, x0} = idx_q;
                busy             = 1'b1;
            end
            StHold: begin
                busy     = 1'b1;
                tt_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        shift_d = shift_q;
        tt_d    = tt_q;
        mis_d   = mis_q;
        sweep_d = sweep_q;
        if (accept) begin
            exp_d   = expected;
            shift_d = '0;
            idx_d   = '0;
            cnt_d   = SettleInit;
        end
        if (state_q == StDrive) begin
            if (sample) begin
                shift_d = shift_in;
                if (last) begin
                    // Table and flag update together so tt is never seen half-built.
                    tt_d  = shift_in;
                    mis_d = (shift_in != exp_q);
                end else begin
                    idx_d = idx_q + 4'd1;
                    cnt_d = SettleInit;
                end
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
        if (handshake) begin
            sweep_d = sweep_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            shift_q <= '0;
            tt_q    <= '0;
            mis_q   <= 1'b0;
            sweep_q <= '0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            shift_q <= shift_d;
            tt_q    <= tt_d;
            mis_q   <= mis_d;
            sweep_q <= sweep_d;
        end
    end

    assign tt        = tt_q;
    assign mismatch  = mis_q;
    assign sweep_cnt = sweep_q;

endmodule

// File: tb/tb_npn4_tt_sweeper.sv
// Bench for npn4_tt_sweeper: two instances (SETTLE=1 and SETTLE=0) driving small netlist models,
// checked every cycle against a timeline model plus hand-computed truth tables.
module tb_npn4_tt_sweeper;

    localparam int unsigned SA = 1;
    localparam int unsigned SB = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  start;
    logic [1:0]  tt_ready;
    logic [15:0] expected [2];
    int          mode [2];  // 0: x0&x1, 1: parity, 2: x0&x1 through one register
    logic        y0a, y0b;
    logic        dly_a = 1'b0;
    logic        dly_b = 1'b0;

    logic [3:0]  xa, xb;
    logic        busy_a, busy_b, mis_a, mis_b, val_a, val_b;
    logic [15:0] tt_a, tt_b;
    logic [7:0]  cnt_a, cnt_b;

    npn4_tt_sweeper #(.SETTLE(SA)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .expected(expected[0]),
        .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]), .y0(y0a),
        .busy(busy_a), .tt(tt_a), .mismatch(mis_a), .tt_valid(val_a),
        .tt_ready(tt_ready[0]), .sweep_cnt(cnt_a)
    );

    npn4_tt_sweeper #(.SETTLE(SB)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .expected(expected[1]),
        .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]), .y0(y0b),
        .busy(busy_b), .tt(tt_b), .mismatch(mis_b), .tt_valid(val_b),
        .tt_ready(tt_ready[1]), .sweep_cnt(cnt_b)
    );

    function automatic logic netlist(int m, logic [3:0] x, logic d);
        case (m)
            0:       return x[0] & x[1];
            1:       return ^x;
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        dly_a <= xa[0] & xa[1];
        dly_b <= xb[0] & xb[1];
    end
    assign y0a = netlist(mode[0], xa, dly_a);
    assign y0b = netlist(mode[1], xb, dly_b);

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int settle_of(int d);
        return (d == 0) ? int'(SA) : int'(SB);
    endfunction

    // Table the sweeper must capture, from the function and what y0 shows on each sample cycle.
    function automatic logic [15:0] ideal_tt(int d);
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] xi;
            logic [3:0] xp;
            int         p;
            xi = 4'(i);
            // Registered netlist shows the previous cycle's minterm; with no settle that is i-1.
            p  = (settle_of(d) > 0) ? i : i - 1;
            xp = 4'(p);
            case (mode[d])
                0:       t[i] = xi[0] & xi[1];
                1:       t[i] = ^xi;
                default: t[i] = (p >= 0) ? (xp[0] & xp[1]) : 1'b0;
            endcase
        end
        return t;
    endfunction

    logic        m_act [2];
    logic        m_val [2];
    int          m_c   [2];
    logic [15:0] m_tt  [2];
    logic [15:0] m_exp [2];
    logic        m_mis [2];
    logic [7:0]  m_cnt [2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_act[d] <= 1'b0; m_val[d] <= 1'b0; m_c[d] <= 0;
                m_tt[d] <= '0; m_exp[d] <= '0; m_mis[d] <= 1'b0; m_cnt[d] <= '0;
            end else if (!m_act[d]) begin
                if (start[d]) begin
                    m_act[d] <= 1'b1;
                    m_c[d]   <= 1;
                    m_exp[d] <= expected[d];
                end
            end else if (m_val[d]) begin
                if (tt_ready[d]) begin
                    m_act[d] <= 1'b0;
                    m_val[d] <= 1'b0;
                    m_cnt[d] <= m_cnt[d] + 8'd1;
                end
            end else begin
                m_c[d] <= m_c[d] + 1;
                if (m_c[d] + 1 == 16 * (settle_of(d) + 1) + 1) begin
                    m_val[d] <= 1'b1;
                    m_tt[d]  <= ideal_tt(d);
                    m_mis[d] <= (ideal_tt(d) != m_exp[d]);
                end
            end
        end
    end

    task automatic cmp(int d, logic [3:0] x, logic busy, logic [15:0] tt, logic mis, logic val,
                       logic [7:0] cnt);
        logic [3:0] ex;
        ex = (m_act[d] && !m_val[d]) ? 4'((m_c[d] - 1) / (settle_of(d) + 1)) : 4'd0;
        chk($sformatf("dut%0d.x", d), 32'(x), 32'(ex));
        chk($sformatf("dut%0d.busy", d), 32'(busy), 32'(m_act[d]));
        chk($sformatf("dut%0d.tt_valid", d), 32'(val), 32'(m_val[d]));
        chk($sformatf("dut%0d.tt", d), 32'(tt), 32'(m_tt[d]));
        chk($sformatf("dut%0d.mismatch", d), 32'(mis), 32'(m_mis[d]));
        chk($sformatf("dut%0d.sweep_cnt", d), 32'(cnt), 32'(m_cnt[d]));
    endtask

    always @(negedge clk) begin
        cmp(0, xa, busy_a, tt_a, mis_a, val_a, cnt_a);
        cmp(1, xb, busy_b, tt_b, mis_b, val_b, cnt_b);
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic valid_of(int d);
        return (d == 0) ? val_a : val_b;
    endfunction

    // Start is high for cycle 0; returns at cycle 1.
    task automatic pulse_start(int d, logic [15:0] e);
        start[d]    = 1'b1;
        expected[d] = e;
        tick();
        start[d]    = 1'b0;
    endtask

    // Cycle counter c begins at 1 (the cycle after acceptance); returns the cycle tt_valid is seen.
    task automatic wait_valid(int d, int limit, output int c);
        c = 1;
        while (!valid_of(d) && c < limit) begin
            tick();
            c++;
        end
        if (!valid_of(d)) chk($sformatf("dut%0d.valid_timeout", d), 32'd0, 32'd1);
    endtask

    int c;

    initial begin
        start    = 2'b00;
        tt_ready = 2'b00;
        expected[0] = '0;
        expected[1] = '0;
        mode[0] = 0;
        mode[1] = 0;
        tick(2);
        chk("reset.tt", 32'(tt_a), 32'h0);
        chk("reset.busy", 32'(busy_a), 32'h0);
        chk("reset.cnt", 32'(cnt_b), 32'h0);
        rst_n = 1'b1;
        tick();

        // AND on SETTLE=1
        tt_ready[0] = 1'b1;
        pulse_start(0, 16'h8888);
        wait_valid(0, 60, c);
        chk("and.valid_cycle", 32'(c), 32'd33);
        chk("and.tt", 32'(tt_a), 32'h8888);
        chk("and.mismatch", 32'(mis_a), 32'h0);
        tick();
        chk("and.sweep_cnt", 32'(cnt_a), 32'd1);
        chk("and.busy_after", 32'(busy_a), 32'd0);

        // Parity with back-pressure on SETTLE=0
        mode[1]     = 1;
        tt_ready[1] = 1'b0;
        pulse_start(1, 16'h6996);
        wait_valid(1, 40, c);
        chk("par.valid_cycle", 32'(c), 32'd17);
        for (int k = 0; k < 5; k++) begin
            chk("par.stall_tt", 32'(tt_b), 32'h6996);
            chk("par.stall_valid", 32'(val_b), 32'd1);
            chk("par.stall_busy", 32'(busy_b), 32'd1);
            chk("par.stall_cnt", 32'(cnt_b), 32'd0);
            tick();
        end
        tt_ready[1] = 1'b1;
        tick();
        tt_ready[1] = 1'b0;
        chk("par.cnt_after", 32'(cnt_b), 32'd1);
        chk("par.busy_after", 32'(busy_b), 32'd0);
        chk("par.tt_kept", 32'(tt_b), 32'h6996);

        // Mismatch, plus starts during DRIVE and on the handshake cycle
        pulse_start(1, 16'h6997);
        tick(3);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        wait_valid(1, 40, c);
        chk("mis.tt", 32'(tt_b), 32'h6996);
        chk("mis.mismatch", 32'(mis_b), 32'd1);
        tick(2);
        tt_ready[1] = 1'b1;
        start[1]    = 1'b1;
        tick();
        start[1]    = 1'b0;
        tt_ready[1] = 1'b0;
        chk("mis.busy_after", 32'(busy_b), 32'd0);
        chk("mis.cnt_after", 32'(cnt_b), 32'd2);
        tick(3);
        chk("mis.still_idle", 32'(busy_b), 32'd0);

        // Settle check with a registered netlist
        mode[0]  = 2;
        mode[1]  = 2;
        tt_ready = 2'b11;
        expected[0] = 16'h8888;
        expected[1] = 16'h8888;
        start = 2'b11;
        tick();
        start = 2'b00;
        wait_valid(1, 40, c);
        chk("settle0.tt", 32'(tt_b), 32'h1110);
        chk("settle0.mismatch", 32'(mis_b), 32'd1);
        wait_valid(0, 60, c);
        chk("settle1.tt", 32'(tt_a), 32'h8888);
        chk("settle1.mismatch", 32'(mis_a), 32'd0);
        tick(2);

        // Reset mid-sweep at cycle 10
        mode[0] = 0;
        pulse_start(0, 16'h8888);
        tick(9);
        rst_n = 1'b0;
        #1;
        chk("rst.x", 32'(xa), 32'h0);
        chk("rst.busy", 32'(busy_a), 32'h0);
        chk("rst.tt", 32'(tt_a), 32'h0);
        chk("rst.mismatch", 32'(mis_a), 32'h0);
        chk("rst.valid", 32'(val_a), 32'h0);
        chk("rst.cnt", 32'(cnt_a), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick();
        pulse_start(0, 16'h8888);
        wait_valid(0, 60, c);
        chk("rst.resweep_cycle", 32'(c), 32'd33);
        chk("rst.resweep_tt", 32'(tt_a), 32'h8888);
        tick();
        chk("rst.resweep_cnt", 32'(cnt_a), 32'd1);

        // 256 back-to-back sweeps on SETTLE=0 (counter cleared by the reset above)
        mode[1] = 1;
        for (int k = 0; k < 256; k++) begin
            pulse_start(1, 16'h6996);
            wait_valid(1, 40, c);
            tick();
            if (k == 254) chk("wrap.cnt255", 32'(cnt_b), 32'd255);
        end
        chk("wrap.cnt0", 32'(cnt_b), 32'd0);
        chk("wrap.tt", 32'(tt_b), 32'h6996);

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
